sbox_word_sched: RTL and testbench
==================================

SBOX_WORD_SCHED -- requirements
Module: sbox_word_sched

Interface
REQ-001 The module SHALL have one parameter: FIXED_PRIO, default 0, where 0 = round-robin arbitration and 1 = requester 0 always has priority.
REQ-002 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous active-high reset.
REQ-005 Port: req0_valid  in  1  requester 0 (key expansion) has a word to substitute.
REQ-006 Port: req0_word  in  32  requester 0 word.
REQ-007 Port: req0_ready  out  1  requester 0 word accepted this cycle.
REQ-008 Port: req1_valid  in  1  requester 1 (round datapath) has a word to substitute.
REQ-009 Port: req1_word  in  32  requester 1 word.
REQ-010 Port: req1_ready  out  1  requester 1 word accepted this cycle.
REQ-011 Port: sbox_in  out  8  byte driven to the shared external combinational AES S-box.
REQ-012 Port: sbox_out  in  8  S-box result for sbox_in, valid in the same cycle.
REQ-013 Port: rsp0_valid  out  1  one-cycle pulse: rsp_word belongs to requester 0.
REQ-014 Port: rsp1_valid  out  1  one-cycle pulse: rsp_word belongs to requester 1.
REQ-015 Port: rsp_word  out  32  registered substituted word.
REQ-016 Port: busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, SUB and DONE, with a 2-bit byte counter cnt.
REQ-018 In IDLE, a transfer SHALL occur on the clock edge where reqN_valid and reqN_ready are both high; the word is captured, the owner is recorded, cnt is set to 0 and the FSM moves to SUB.
REQ-019 The reqN_ready outputs SHALL be combinational from reqN_valid, state and the last grant, and SHALL be high only in IDLE; at most one ready SHALL be high in any cycle.
REQ-020 With a single valid requester in IDLE, that requester SHALL be granted.
REQ-021 When both requesters are valid, FIXED_PRIO=1 SHALL grant requester 0; FIXED_PRIO=0 SHALL grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-022 In SUB, sbox_in SHALL equal the captured word's byte cnt, MSB-first: cnt0 = bits 31:24 through cnt3 = bits 7:0.
REQ-023 At each SUB edge, sbox_out SHALL be written into the same byte position of the result register and cnt SHALL increment; the edge with cnt=3 SHALL move the FSM to DONE.
REQ-024 In DONE, rsp0_valid or rsp1_valid (matching the owner) SHALL be high for exactly one cycle with rsp_word complete, and the next state SHALL be IDLE.
REQ-025 Latency: acceptance at edge E0 SHALL give the response pulse in the cycle following edge E4; throughput is one word per 6 cycles.
REQ-026 rsp_word SHALL hold its value until the next DONE; responses have no backpressure.
REQ-027 sbox_in SHALL be 8'h00 outside SUB.
REQ-028 Requesters SHALL keep reqN_valid and reqN_word stable until accepted, and SHALL NOT derive reqN_valid from reqN_ready.
REQ-029 Valid edges arriving while busy SHALL be ignored until IDLE; a request held through DONE SHALL be arbitrated in the following IDLE cycle.
REQ-030 The cnt wrap from 3 to 0 SHALL occur only on the SUB-to-DONE transition.

Reset
REQ-031 While rst is high, regardless of clock, the block SHALL set: state IDLE; cnt 0; last_grant 1; rsp_word 32'h0; rsp0_valid, rsp1_valid and busy low; captured word 0; sbox_in 8'h00.
REQ-032 Reset during SUB or DONE SHALL abort the word with no response pulse; after release, the first request SHALL be accepted in IDLE.

Verification
REQ-033 Single request: req0_word=32'h0053FF01 -> req0_ready at E0; sbox_in sequence 00,53,FF,01; rsp0_valid one cycle after E4; rsp_word=32'h63ED167C.
REQ-034 Simultaneous request: req0=32'h52525252 and req1=32'h01010101 valid from reset release, FIXED_PRIO=0 -> rsp0 returns 32'h00000000 first, then rsp1 returns 32'h7C7C7C7C; no ready is asserted while busy.
REQ-035 Round-robin: both requesters held valid for 4 transactions -> grant order 0,1,0,1; with FIXED_PRIO=1 -> order 0,0,0,0, and req1 is never ready.
REQ-036 Mid-op reset: rst asserted at cnt=2 -> busy=0, rsp_word=0, no rsp pulse; req1=32'h000000FF afterwards -> rsp1 gives 32'h63636316.
REQ-037 Back-to-back: req1 held valid through DONE -> req1_ready in the IDLE cycle right after DONE; 6-cycle spacing between successive rsp pulses.

Source files
------------

// File: rtl/sbox_word_sched.sv
// sbox_word_sched: arbitrates two 32-bit requesters onto one shared S-box, substituting one byte per cycle
module sbox_word_sched #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_word,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_word,
  output logic        req1_ready,
  output logic [7:0]  sbox_in,
  input  logic [7:0]  sbox_out,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_word,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic        last_grant, owner, win0;
  logic [31:0] word, res;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    win0 = req0_valid && (!req1_valid || FIXED_PRIO != 0 || last_grant);
    req0_ready = state == IDLE && win0;
    req1_ready = state == IDLE && req1_valid && !win0;
    sbox_in = state == SUB ? word[{~cnt, 3'b000} +: 8] : 8'h00;
    rsp0_valid = state == DONE && !owner;
    rsp1_valid = state == DONE && owner;
    busy = state != IDLE;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (req0_ready || req1_ready) ? SUB : IDLE;
      SUB:     state_nxt = cnt == 2'd3 ? DONE : SUB;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      last_grant <= 1'b1;
      owner <= 1'b0;
      word <= '0;
      res <= '0;
      rsp_word <= '0;
    end else begin
      if (req0_ready || req1_ready) begin
        word <= req1_ready ? req1_word : req0_word;
        owner <= req1_ready;
        last_grant <= req1_ready;
        cnt <= '0;
      end
      if (state == SUB) begin
        res[{~cnt, 3'b000} +: 8] <= sbox_out;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) rsp_word <= {res[31:8], sbox_out};
      end
    end
endmodule

// File: tb/tb_sbox_word_sched.sv
// tb_sbox_word_sched: table, directed and randomized checks of sbox_word_sched against a transaction-level model
module tb_sbox_word_sched;
  logic clk, rst;
  logic v0, v1, r0, r1, p0, p1, bz;
  logic [31:0] w0, w1, rw;
  logic [7:0] sb_in, sb_out;
  logic fv0, fv1, f_r0, f_r1, f_p0, f_p1, f_bz;
  logic [31:0] fw0, fw1, f_rw;
  logic [7:0] f_sb_in, f_sb_out;
  logic [7:0] sbox_t [256];
  int vec, errs, tcnt;
  logic [2:0] p;
  logic own, mlast;
  logic [31:0] mw, mrsp;
  logic s_r0, s_r1, s_p0, s_p1, f_pv, f_p, f_r1_any;
  logic [31:0] s_rw;
  typedef struct {logic own; logic [31:0] w; logic [31:0] exp;} vec_t;
  vec_t tbl [6];

  sbox_word_sched #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_word(w0), .req0_ready(r0),
    .req1_valid(v1), .req1_word(w1), .req1_ready(r1),
    .sbox_in(sb_in), .sbox_out(sb_out),
    .rsp0_valid(p0), .rsp1_valid(p1), .rsp_word(rw), .busy(bz)
  );
  sbox_word_sched #(.FIXED_PRIO(1)) dutf (
    .clk(clk), .rst(rst),
    .req0_valid(fv0), .req0_word(fw0), .req0_ready(f_r0),
    .req1_valid(fv1), .req1_word(fw1), .req1_ready(f_r1),
    .sbox_in(f_sb_in), .sbox_out(f_sb_out),
    .rsp0_valid(f_p0), .rsp1_valid(f_p1), .rsp_word(f_rw), .busy(f_bz)
  );
  assign sb_out = sbox_t[sb_in];
  assign f_sb_out = sbox_t[f_sb_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sub(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_t[w[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // p counts cycles since acceptance: 1..4 feed bytes MSB-first, 5 is the response cycle
  task automatic tick();
    logic e0, e1;
    logic [31:0] sh;
    #1;
    if (rst) begin p = 0; mlast = 1; mrsp = 0; mw = 0; end
    e0 = p == 0 && v0 && (!v1 || mlast);
    e1 = p == 0 && v1 && !e0;
    sh = (p >= 1 && p <= 4) ? mw >> (8 * (4 - int'(p))) : 32'h0;
    chk("req0_ready", r0, e0);
    chk("req1_ready", r1, e1);
    chk("sbox_in", sb_in, sh[7:0]);
    chk("rsp0_valid", p0, p == 5 && !own);
    chk("rsp1_valid", p1, p == 5 && own);
    chk("rsp_word", rw, mrsp);
    chk("busy", bz, p != 0);
    s_r0 = r0; s_r1 = r1; s_p0 = p0; s_p1 = p1; s_rw = rw;
    f_pv = f_p0 | f_p1; f_p = f_p1; f_r1_any = f_r1_any | f_r1;
    @(posedge clk);
    tcnt++;
    if (!rst) begin
      if (p == 0) begin
        if (e0 || e1) begin p = 1; own = e1; mlast = e1; mw = e1 ? w1 : w0; end
      end else if (p == 5) p = 0;
      else begin
        if (p == 4) mrsp = sub(mw);
        p = p + 1;
      end
    end
    #1;
  endtask

  task automatic do_xact(input logic o, input logic [31:0] w, input logic [31:0] e);
    int n;
    logic got;
    if (o) begin v1 = 1; w1 = w; end else begin v0 = 1; w0 = w; end
    got = 0; n = 0;
    while (n < 20 && !got) begin tick(); got = o ? s_r1 : s_r0; n++; end
    chk("accept", got, 1);
    v0 = 0; v1 = 0;
    n = 0;
    while (n < 20 && !(s_p0 || s_p1)) begin tick(); n++; end
    chk("latency", n, 5);
    chk("rsp_owner", s_p1, o);
    chk("rsp_value", s_rw, e);
  endtask

  initial begin
    int k, lim, fk, last_t;
    logic [3:0] ord, ford;
    logic [31:0] words [4];
    sbox_t = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    tbl[0] = '{1'b0, 32'h0053FF01, 32'h63ED167C};
    tbl[1] = '{1'b0, 32'h52525252, 32'h00000000};
    tbl[2] = '{1'b1, 32'h01010101, 32'h7C7C7C7C};
    tbl[3] = '{1'b1, 32'h000000FF, 32'h63636316};
    tbl[4] = '{1'b0, 32'hFFFFFFFF, 32'h16161616};
    tbl[5] = '{1'b1, 32'h00000000, 32'h63636363};
    vec = 0; errs = 0; tcnt = 0;
    p = 0; own = 0; mlast = 1; mw = 0; mrsp = 0; f_r1_any = 0;
    v0 = 0; v1 = 0; w0 = 0; w1 = 0; fv0 = 0; fv1 = 0; fw0 = 0; fw1 = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    for (int i = 0; i < 6; i++) do_xact(tbl[i].own, tbl[i].w, tbl[i].exp);
    // abort a word while cnt=2
    v0 = 1; w0 = 32'hA5A5A5A5; k = 0;
    while (k < 20 && !s_r0) begin tick(); k++; end
    v0 = 0;
    tick();
    tick();
    chk("midop_busy", bz, 1);
    rst = 1;
    #1;
    chk("abort_busy", bz, 0);
    chk("abort_rsp_word", rw, 0);
    chk("abort_pulse", {p0, p1}, 0);
    chk("abort_sbox_in", sb_in, 0);
    tick();
    rst = 0;
    repeat (6) tick();
    do_xact(1'b1, 32'h000000FF, 32'h63636316);
    // both requesters held valid on both instances from reset release
    rst = 1;
    tick();
    rst = 0;
    v0 = 1; v1 = 1; w0 = 32'h52525252; w1 = 32'h01010101;
    fv0 = 1; fv1 = 1; fw0 = 32'h52525252; fw1 = 32'h01010101;
    f_r1_any = 0; k = 0; fk = 0; lim = 0; last_t = 0; ord = 0; ford = 4'hF;
    while (k < 4 && lim < 60) begin
      tick();
      lim++;
      if (s_p0 || s_p1) begin
        ord[k] = s_p1;
        words[k] = s_rw;
        if (k > 0) chk("rsp_spacing", tcnt - last_t, 6);
        last_t = tcnt;
        k++;
      end
      if (f_pv && fk < 4) begin ford[fk] = f_p; fk++; end
    end
    v0 = 0; v1 = 0; fv0 = 0; fv1 = 0;
    chk("rr_count", k, 4);
    chk("rr_order", ord, 4'b1010);
    chk("rr_first_word", words[0], 32'h00000000);
    chk("rr_second_word", words[1], 32'h7C7C7C7C);
    chk("fixed_count", fk, 4);
    chk("fixed_order", ford, 4'b0000);
    chk("fixed_req1_ready", f_r1_any, 0);
    repeat (3) tick();
    // randomized traffic with occasional asynchronous resets
    repeat (1500) begin
      if (!v0 || s_r0) begin
        v0 = ($urandom % 3) != 0;
        w0 = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
      end
      if (!v1 || s_r1) begin
        v1 = ($urandom % 3) != 0;
        w1 = ($urandom % 8 == 0) ? 32'h00000000 : $urandom;
      end
      rst = ($urandom % 80) == 0;
      tick();
    end
    rst = 0; v0 = 0; v1 = 0;
    repeat (8) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
